// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Define MDU_ACCUMULATE_EN to compile in the multiply-accumulate (ACC) state.
`ifndef W_FUNC
`define W_FUNC 2
`endif
`ifndef FUNC_MUL
`define FUNC_MUL 2'b01
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 2'b10
`endif

module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [`W_FUNC-1:0] func,
    input  logic               sign,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [1:0]         acc,
    input  logic               flush,
    input  logic               hi_we,
    input  logic               lo_we,
    input  logic [WIDTH-1:0]   hi_wdata,
    input  logic [WIDTH-1:0]   lo_wdata,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               done
);
    localparam int CW = $clog2(WIDTH);

`ifdef MDU_ACCUMULATE_EN
    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_ACC, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_DONE} state_t;
`endif

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   p_hi_q, p_hi_d;
    logic [WIDTH-1:0]   p_lo_q, p_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_mul_q, is_mul_d;
    logic               sign_q, sign_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_wr, lo_wr;
    logic               a_neg, b_neg;
    logic               acc_go;

`ifdef MDU_ACCUMULATE_EN
    logic [1:0]         acc_q, acc_d;
`else
    logic               unused_acc;
    assign unused_acc = ^acc;
`endif

    function automatic logic [WIDTH-1:0] cneg(input logic n, input logic [WIDTH-1:0] x);
        return n ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg2(input logic n, input logic [2*WIDTH-1:0] x);
        return n ? -x : x;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        is_mul_d = is_mul_q;
        sign_d   = sign_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
`ifdef MDU_ACCUMULATE_EN
        acc_d    = acc_q;
        acc_go   = is_mul_q && (acc_q == 2'b01 || acc_q == 2'b10);
`else
        acc_go   = 1'b0;
`endif
        hi_wr    = hi_we ? hi_wdata : hi_q;
        lo_wr    = lo_we ? lo_wdata : lo_q;
        hi_d     = hi_wr;
        lo_d     = lo_wr;
        a_neg    = sign_q & m_q[WIDTH-1];
        b_neg    = sign_q & p_lo_q[WIDTH-1];
        mul_sum  = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, m_q} : '0);
        div_trial = {p_hi_q, p_lo_q[WIDTH-1]} - {1'b0, m_q};
        prod_fix = cneg2(q_neg_q, {p_hi_q, p_lo_q});

        case (state_q)
            S_IDLE: begin
                if (start && (func == `FUNC_MUL || func == `FUNC_DIV)) begin
                    state_d  = S_PREP;
                    m_d      = src_a;
                    p_lo_d   = src_b;
                    is_mul_d = (func == `FUNC_MUL);
                    sign_d   = sign;
`ifdef MDU_ACCUMULATE_EN
                    acc_d    = acc;
`endif
                end
            end
            S_PREP: begin
                // Raw operands sit in m/p_lo; swap in magnitudes ordered for the op.
                if (is_mul_q) begin
                    m_d     = cneg(a_neg, m_q);
                    p_lo_d  = cneg(b_neg, p_lo_q);
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = 1'b0;
                end else begin
                    m_d     = cneg(b_neg, p_lo_q);
                    p_lo_d  = cneg(a_neg, m_q);
                    q_neg_d = (a_neg ^ b_neg) && (p_lo_q != '0);
                    r_neg_d = a_neg;
                end
                p_hi_d  = '0;
                cnt_d   = CW'(WIDTH - 1);
                state_d = S_CALC;
            end
            S_CALC: begin
                if (is_mul_q) begin
                    p_hi_d = mul_sum[WIDTH:1];
                    p_lo_d = {mul_sum[0], p_lo_q[WIDTH-1:1]};
                end else if (!div_trial[WIDTH]) begin
                    p_hi_d = div_trial[WIDTH-1:0];
                    p_lo_d = {p_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    p_hi_d = {p_hi_q[WIDTH-2:0], p_lo_q[WIDTH-1]};
                    p_lo_d = {p_lo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
`ifdef MDU_ACCUMULATE_EN
                    state_d = acc_go ? S_ACC : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef MDU_ACCUMULATE_EN
            S_ACC: begin
                // Accumulated sum is already signed; park it with the sign flag cleared.
                {p_hi_d, p_lo_d} = (acc_q == 2'b01) ? ({hi_q, lo_q} + prod_fix)
                                                    : ({hi_q, lo_q} - prod_fix);
                q_neg_d = 1'b0;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
                if (is_mul_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else begin
                    hi_d = cneg(r_neg_q, p_hi_q);
                    lo_d = cneg(q_neg_q, p_lo_q);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_wr;
            lo_d    = lo_wr;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            m_q      <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_mul_q <= 1'b0;
            sign_q   <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MDU_ACCUMULATE_EN
            acc_q    <= 2'b00;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_mul_q <= is_mul_d;
            sign_q   <= sign_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MDU_ACCUMULATE_EN
            acc_q    <= acc_d;
`endif
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter at WIDTH=32 with hand-computed expectations.
`ifndef W_FUNC
`define W_FUNC 2
`endif
`ifndef FUNC_MUL
`define FUNC_MUL 2'b01
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 2'b10
`endif

module tb_mdu_iter;
    localparam int W = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [`W_FUNC-1:0] func;
    logic               sign;
    logic [W-1:0]       src_a, src_b;
    logic [1:0]         acc;
    logic               flush;
    logic               hi_we, lo_we;
    logic [W-1:0]       hi_wdata, lo_wdata;
    logic [W-1:0]       hi, lo;
    logic               busy, done;

    int n_vec = 0;
    int n_err = 0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func), .sign(sign),
        .src_a(src_a), .src_b(src_b), .acc(acc), .flush(flush),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where done is seen.
    task automatic run_op(input logic [1:0] f, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [1:0] ac, output int lat);
        int  cyc;
        bit  seen;
        func = f; sign = s; src_a = a; src_b = b; acc = ac; start = 1'b1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1 start = 1'b0;
            @(negedge clk);
            if (done) seen = 1;
        end
        lat = seen ? cyc : -1;
    endtask

    task automatic finish_op();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
        hi_we = 1'b1; lo_we = 1'b1; hi_wdata = h; lo_wdata = l;
        @(posedge clk);
        #1 hi_we = 1'b0; lo_we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  lat;
        int  cyc;
        bit  saw_done;
        rst_n = 1'b1; start = 0; func = '0; sign = 0; src_a = '0; src_b = '0; acc = '0;
        flush = 0; hi_we = 0; lo_we = 0; hi_wdata = '0; lo_wdata = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        run_op(`FUNC_MUL, 1'b1, 32'hFFFFFFFD, 32'h7, 2'b00, lat);
        check("smul_lat", 64'(lat), 64'd34);
        finish_op();
        check("smul_hi", 64'(hi), 64'hFFFFFFFF);
        check("smul_lo", 64'(lo), 64'hFFFFFFEB);
        check("done_1cyc", 64'(done), 64'd0);

        run_op(`FUNC_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, lat);
        finish_op();
        check("umul_max", {32'(hi), 32'(lo)}, 64'hFFFFFFFE_00000001);

        run_op(`FUNC_MUL, 1'b1, 32'h80000000, 32'h80000000, 2'b00, lat);
        finish_op();
        check("smul_min", {32'(hi), 32'(lo)}, 64'h40000000_00000000);

        run_op(`FUNC_DIV, 1'b0, 32'd100, 32'd7, 2'b00, lat);
        check("udiv_lat", 64'(lat), 64'd34);
        finish_op();
        check("udiv_lo", 64'(lo), 64'd14);
        check("udiv_hi", 64'(hi), 64'd2);

        run_op(`FUNC_DIV, 1'b1, 32'hFFFFFFF9, 32'd2, 2'b00, lat);
        finish_op();
        check("sdiv_lo", 64'(lo), 64'hFFFFFFFD);
        check("sdiv_hi", 64'(hi), 64'hFFFFFFFF);

        run_op(`FUNC_DIV, 1'b0, 32'd5, 32'd0, 2'b00, lat);
        finish_op();
        check("div0_lo", 64'(lo), 64'hFFFFFFFF);
        check("div0_hi", 64'(hi), 64'd5);

        run_op(`FUNC_DIV, 1'b1, 32'hFFFFFFFB, 32'd0, 2'b00, lat);
        finish_op();
        check("sdiv0_lo", 64'(lo), 64'hFFFFFFFF);
        check("sdiv0_hi", 64'(hi), 64'hFFFFFFFB);

        run_op(`FUNC_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 2'b00, lat);
        finish_op();
        check("ovf_lo", 64'(lo), 64'h80000000);
        check("ovf_hi", 64'(hi), 64'd0);

        // Non-arithmetic func must not launch.
        func = 2'b11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("noop_busy", 64'(busy), 64'd0);

        // Flush and start together in IDLE.
        func = `FUNC_MUL; src_a = 32'd3; src_b = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("flush_start_busy", 64'(busy), 64'd0);

        write_hilo(32'hAAAA5555, 32'h12345678);
        check("mthi", 64'(hi), 64'hAAAA5555);
        check("mtlo", 64'(lo), 64'h12345678);

        // DIV flushed at cycle 10, with an extra start attempted while busy.
        func = `FUNC_DIV; sign = 1'b0; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        cyc = 0; saw_done = 0;
        while (cyc < 45) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) start = 1'b0;
            if (cyc == 5) begin func = `FUNC_MUL; src_a = 32'd9; src_b = 32'd9; start = 1'b1; end
            if (cyc == 6) start = 1'b0;
            if (cyc == 10) flush = 1'b1;
            if (cyc == 11) flush = 1'b0;
            @(negedge clk);
            if (done) saw_done = 1;
            if (cyc == 10) check("busy_before_flush", 64'(busy), 64'd1);
            if (cyc == 11) check("busy_after_flush", 64'(busy), 64'd0);
        end
        check("flush_no_done", 64'(saw_done), 64'd0);
        check("flush_hi", 64'(hi), 64'hAAAA5555);
        check("flush_lo", 64'(lo), 64'h12345678);

        // MTHI/MTLO in the DONE cycle loses to the result.
        run_op(`FUNC_MUL, 1'b0, 32'd6, 32'd7, 2'b00, lat);
        hi_we = 1'b1; lo_we = 1'b1; hi_wdata = 32'hDEADBEEF; lo_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 begin hi_we = 1'b0; lo_we = 1'b0; end
        @(negedge clk);
        check("done_wr_hi", 64'(hi), 64'd0);
        check("done_wr_lo", 64'(lo), 64'd42);

        // Asynchronous reset mid-CALC, then an immediate start.
        func = `FUNC_MUL; sign = 1'b0; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(`FUNC_MUL, 1'b0, 32'd3, 32'd4, 2'b00, lat);
        check("post_rst_lat", 64'(lat), 64'd34);
        finish_op();
        check("post_rst_lo", 64'(lo), 64'd12);
        check("post_rst_hi", 64'(hi), 64'd0);

        write_hilo(32'h0, 32'hFFFFFFFF);
`ifdef MDU_ACCUMULATE_EN
        run_op(`FUNC_MUL, 1'b0, 32'd1, 32'd1, 2'b01, lat);
        check("macc_lat", 64'(lat), 64'd35);
        finish_op();
        check("macc_hi", 64'(hi), 64'd1);
        check("macc_lo", 64'(lo), 64'd0);
        run_op(`FUNC_MUL, 1'b0, 32'd2, 32'd3, 2'b10, lat);
        finish_op();
        check("msub", {32'(hi), 32'(lo)}, 64'h00000000_FFFFFFFA);
`else
        run_op(`FUNC_MUL, 1'b0, 32'd1, 32'd1, 2'b01, lat);
        check("acc_ign_lat", 64'(lat), 64'd34);
        finish_op();
        check("acc_ign_hi", 64'(hi), 64'd0);
        check("acc_ign_lo", 64'(lo), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
